// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding, parity modes and a
// 2-of-3 majority helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle pulse every P_DIV enabled cycles,
// counter held at zero while disabled.
module uart_os_tick #(
  parameter int P_DIV = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (P_DIV > 1) ? $clog2(P_DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;
  logic         wrap;

  assign wrap   = (cnt_q == W'(P_DIV - 1));
  assign o_tick = i_en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en)
      cnt_d = '0;
    else if (wrap)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x oversampling UART receiver with majority voting, optional parity,
// 1 or 2 stop bits and break detection.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BURD_RATE  = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_CHECK_ON   = 0,
  parameter int P_UART_STOP_WIDTH = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data,
  output logic                         o_uart_rx_valid,
  output logic                         o_parity_err,
  output logic                         o_frame_err,
  output logic                         o_busy
);

  localparam int DW    = P_UART_DATA_WIDTH;
  localparam int DIV_R = P_SYSTEM_CLK / (P_UART_BURD_RATE * 16);
  localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
  localparam logic [1:0] MODE = 2'(P_UART_CHECK_ON);

  uart_state_e   state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [3:0]    os_cnt_q, os_cnt_d;
  logic [1:0]    smp_q, smp_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic          ferr_flag_q, ferr_flag_d;
  logic          par_bad_q, par_bad_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  logic tick, rx, fall, vote, mid, last, ferr_now;

  uart_os_tick #(.P_DIV(DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (state_q != S_IDLE),
    .o_tick (tick)
  );

  assign rx       = sync2_q;
  assign fall     = prev_q & ~rx;
  assign vote     = maj3(smp_q[1], smp_q[0], rx);
  assign mid      = tick && (os_cnt_q == 4'd9);
  assign last     = tick && (os_cnt_q == 4'd15);
  assign ferr_now = ferr_flag_q | ~vote;

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    smp_d       = smp_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    ferr_flag_d = ferr_flag_q;
    par_bad_d   = par_bad_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    if (tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
      if (os_cnt_q == 4'd7) smp_d[1] = rx;
      if (os_cnt_q == 4'd8) smp_d[0] = rx;
    end
    unique case (state_q)
      S_IDLE: begin
        os_cnt_d    = '0;
        bit_cnt_d   = '0;
        stop_cnt_d  = 1'b0;
        ferr_flag_d = 1'b0;
        par_bad_d   = 1'b0;
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (mid && vote) state_d = S_IDLE;
        else if (last) state_d = S_DATA;
      end
      S_DATA: begin
        if (mid) shift_d = {vote, shift_q[DW-1:1]};
        if (last) begin
          if (bit_cnt_q == 3'(DW - 1)) begin
            bit_cnt_d = '0;
            state_d   = (MODE != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (mid)
          par_bad_d = ((^shift_q) ^ vote) != (MODE == PAR_ODD);
        if (last) state_d = S_STOP;
      end
      S_STOP: begin
        // Final stop bit is resolved at its vote, not at its end,
        // so the next start edge can never be missed.
        if (mid) begin
          if (stop_cnt_q == 1'(P_UART_STOP_WIDTH - 1)) begin
            data_d = shift_q;
            if (ferr_now) begin
              ferr_d  = 1'b1;
              state_d = rx ? S_IDLE : S_BREAK_WAIT;
            end else if (par_bad_q) begin
              perr_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              valid_d = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            ferr_flag_d = ferr_now;
          end
        end else if (last) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      S_BREAK_WAIT: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      os_cnt_q    <= '0;
      smp_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      ferr_flag_q <= 1'b0;
      par_bad_q   <= 1'b0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= i_uart_rx;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      os_cnt_q    <= os_cnt_d;
      smp_q       <= smp_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      ferr_flag_q <= ferr_flag_d;
      par_bad_q   <= par_bad_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign o_uart_rx_data  = data_q;
  assign o_uart_rx_valid = valid_q;
  assign o_parity_err    = perr_q;
  assign o_frame_err     = ferr_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench: three receiver configurations (plain, odd parity,
// two stop bits) each on its own serial line.
module tb_uart_rx_oversample;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx = 3'b111;
  logic [7:0] data [3];
  logic [2:0] valid, perr, ferr, busy;

  int errors = 0;
  int checks = 0;
  int vcnt [3] = '{0, 0, 0};
  int pcnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};
  int multi = 0;
  logic [7:0] qa [$];

  always #5 clk = ~clk;

  uart_rx_oversample #(
    .P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000),
    .P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(1)
  ) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx[0]),
    .o_uart_rx_data(data[0]), .o_uart_rx_valid(valid[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_busy(busy[0])
  );

  uart_rx_oversample #(
    .P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000),
    .P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(1), .P_UART_STOP_WIDTH(1)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx[1]),
    .o_uart_rx_data(data[1]), .o_uart_rx_valid(valid[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_busy(busy[1])
  );

  uart_rx_oversample #(
    .P_SYSTEM_CLK(1_600_000), .P_UART_BURD_RATE(10_000),
    .P_UART_DATA_WIDTH(8), .P_UART_CHECK_ON(0), .P_UART_STOP_WIDTH(2)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx[2]),
    .o_uart_rx_data(data[2]), .o_uart_rx_valid(valid[2]),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_busy(busy[2])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) vcnt[i] <= vcnt[i] + 1;
      if (perr[i]) pcnt[i] <= pcnt[i] + 1;
      if (ferr[i]) fcnt[i] <= fcnt[i] + 1;
      if (int'(valid[i]) + int'(perr[i]) + int'(ferr[i]) > 1)
        multi <= multi + 1;
    end
    if (valid[0]) qa.push_back(data[0]);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int sel, input logic b);
    rx[sel] = b;
    cyc(BIT);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] d,
                           input bit par_en, input logic par);
    send_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
    if (par_en) send_bit(sel, par);
    send_bit(sel, 1'b1);
  endtask

  task automatic test_reset;
    cyc(5);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid[i], perr[i], ferr[i], busy[i]} !== 4'b0 ||
          data[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_out[%0d]: got v%b p%b f%b b%b d=%h, want all 0",
                 i, valid[i], perr[i], ferr[i], busy[i], data[i]);
      end
    end
    rst_n = 1'b1;
    cyc(20);
    checks++;
    if (busy !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 000", busy);
    end
  endtask

  task automatic test_basic;
    int v0, p0, f0;
    v0 = vcnt[0]; p0 = pcnt[0]; f0 = fcnt[0];
    send_byte(0, 8'hA5, 1'b0, 1'b0);
    cyc(20);
    checks++;
    if (vcnt[0] - v0 !== 1) begin
      errors++;
      $display("FAIL basic_valid: pulses=%0d want 1", vcnt[0] - v0);
    end
    checks++;
    if (data[0] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_data: got %h want a5", data[0]);
    end
    checks++;
    if (pcnt[0] != p0 || fcnt[0] != f0) begin
      errors++;
      $display("FAIL basic_noerr: perr=%0d ferr=%0d want 0 0",
               pcnt[0] - p0, fcnt[0] - f0);
    end
  endtask

  task automatic test_parity;
    int v0, p0;
    v0 = vcnt[1]; p0 = pcnt[1];
    send_byte(1, 8'h03, 1'b1, 1'b0);
    cyc(20);
    checks++;
    if (pcnt[1] - p0 !== 1 || vcnt[1] !== v0) begin
      errors++;
      $display("FAIL parity_bad: perr=%0d valid=%0d want 1 0",
               pcnt[1] - p0, vcnt[1] - v0);
    end
    checks++;
    if (data[1] !== 8'h03) begin
      errors++;
      $display("FAIL parity_data: got %h want 03", data[1]);
    end
    send_byte(1, 8'h03, 1'b1, 1'b1);
    cyc(20);
    checks++;
    if (vcnt[1] - v0 !== 1 || pcnt[1] - p0 !== 1) begin
      errors++;
      $display("FAIL parity_good: valid=%0d perr=%0d want 1 1",
               vcnt[1] - v0, pcnt[1] - p0);
    end
  endtask

  task automatic test_break;
    int v0, p0, f0, lows, t;
    v0 = vcnt[2]; p0 = pcnt[2]; f0 = fcnt[2];
    lows = 0;
    send_bit(2, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(2, (8'h3C >> i) & 1'b1);
    send_bit(2, 1'b1);
    rx[2] = 1'b0;
    for (int i = 0; i < 4 * BIT; i++) begin
      @(negedge clk);
      if (!busy[2]) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL break_busy: busy low %0d cycles want 0", lows);
    end
    checks++;
    if (fcnt[2] - f0 !== 1 || vcnt[2] != v0 || pcnt[2] != p0) begin
      errors++;
      $display("FAIL break_ferr: ferr=%0d valid=%0d perr=%0d want 1 0 0",
               fcnt[2] - f0, vcnt[2] - v0, pcnt[2] - p0);
    end
    checks++;
    if (data[2] !== 8'h3C) begin
      errors++;
      $display("FAIL break_data: got %h want 3c", data[2]);
    end
    rx[2] = 1'b1;
    t = 0;
    while (busy[2] && t < 10) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL break_release: busy=%b after 10 cycles want 0", busy[2]);
    end
    cyc(2 * BIT);
    checks++;
    if (fcnt[2] - f0 !== 1 || vcnt[2] != v0 || pcnt[2] != p0) begin
      errors++;
      $display("FAIL break_extra: ferr=%0d valid=%0d want 1 0",
               fcnt[2] - f0, vcnt[2] - v0);
    end
  endtask

  task automatic test_glitch;
    int v0, p0, f0, t;
    v0 = vcnt[0]; p0 = pcnt[0]; f0 = fcnt[0];
    rx[0] = 1'b0;
    cyc(10);
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_start: busy=%b want 1", busy[0]);
    end
    cyc(30);
    rx[0] = 1'b1;
    t = 40;
    while (busy[0] && t < 170) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: busy=%b after 170 cycles want 0", busy[0]);
    end
    cyc(2 * BIT);
    checks++;
    if (vcnt[0] != v0 || pcnt[0] != p0 || fcnt[0] != f0) begin
      errors++;
      $display("FAIL glitch_pulse: v=%0d p=%0d f=%0d want 0 0 0",
               vcnt[0] - v0, pcnt[0] - p0, fcnt[0] - f0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [3];
    int v0;
    exp = '{8'h00, 8'hFF, 8'h55};
    v0 = vcnt[0];
    qa.delete();
    for (int i = 0; i < 3; i++) send_byte(0, exp[i], 1'b0, 1'b0);
    cyc(20);
    checks++;
    if (vcnt[0] - v0 !== 3 || qa.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d want 3", vcnt[0] - v0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= qa.size() || qa[i] !== exp[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i,
                 (i < qa.size()) ? qa[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int v0, p0, f0;
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    v0 = vcnt[0]; p0 = pcnt[0]; f0 = fcnt[0];
    rst_n = 1'b0;
    cyc(3);
    checks++;
    if (busy[0] !== 1'b0 || data[0] !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_state: busy=%b data=%h want 0 00",
               busy[0], data[0]);
    end
    rx[0] = 1'b1;
    rst_n = 1'b1;
    cyc(2 * BIT);
    checks++;
    if (vcnt[0] != v0 || pcnt[0] != p0 || fcnt[0] != f0) begin
      errors++;
      $display("FAIL rst_mid_drop: v=%0d p=%0d f=%0d want 0 0 0",
               vcnt[0] - v0, pcnt[0] - p0, fcnt[0] - f0);
    end
    send_byte(0, 8'h34, 1'b0, 1'b0);
    cyc(20);
    checks++;
    if (vcnt[0] - v0 !== 1 || data[0] !== 8'h34) begin
      errors++;
      $display("FAIL rst_mid_next: pulses=%0d data=%h want 1 34",
               vcnt[0] - v0, data[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_break;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL one_hot_pulse: overlapping pulses=%0d want 0", multi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
